// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - RV32I memory-access codes, LSU state encoding and lane helpers
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int READ_LAT_MAX = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_t;

    function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = !a[0];
            F3_W:        ok = (a == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok && !(we && f3[2]);
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << a;
            F3_H:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wd[7:0]}};
            F3_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_dm_if.sv
// rtl/lsu_dm_if.sv - request/response handshake between the MEM stage and the LSU
interface lsu_dm_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - byte/half-word selection and sign/zero extension of a read word
module lsu_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] mem_data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = mem_data[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
        case (funct3)
            F3_B:    rdata = {{24{b[7]}}, b};
            F3_BU:   rdata = {24'h0, b};
            F3_H:    rdata = {{16{h[15]}}, h};
            F3_HU:   rdata = {16'h0, h};
            default: rdata = mem_data;
        endcase
    end
endmodule

// File: rtl/lsu_dm.sv
// rtl/lsu_dm.sv - load/store unit driving the data-memory port
module lsu_dm
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    lsu_dm_if.slave           lsu,
    output logic [ADDR_W-1:0] address_dm,
    output logic [31:0]       writedata_dm,
    output logic [3:0]        byte_en,
    output logic              memread_dm,
    output logic              memwrite_dm,
    input  logic [31:0]       mem_data
);
    localparam int         LAT_I = (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
    localparam logic [1:0] LAT   = LAT_I[1:0];

    lsu_state_t        state_q, state_d;
    logic [1:0]        cnt_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       load_data;
    logic              accept;
    logic              legal;
    logic              unused_addr_hi;

    // Address bits above ADDR_W wrap away; fold them so they count as consumed.
    assign unused_addr_hi = ^lsu.req_addr;

    assign accept = lsu.req_valid && (state_q == S_IDLE);
    assign legal  = is_legal(lsu.req_we, lsu.req_funct3, lsu.req_addr[1:0]);

    lsu_load_align u_align (
        .mem_data (mem_data),
        .addr_lo  (addr_q[1:0]),
        .funct3   (f3_q),
        .rdata    (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = !legal ? S_RESP : (lsu.req_we ? S_WRITE : S_READ);
            S_WRITE: state_d = S_RESP;
            S_READ:  if (cnt_q == LAT) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture; rdata is cleared on acceptance so stores and errors return 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= 2'd0;
            f3_q    <= lsu.req_funct3;
            addr_q  <= lsu.req_addr[ADDR_W-1:0];
            wdata_q <= lsu.req_wdata;
            rdata_q <= 32'h0;
            err_q   <= !legal;
        end else if (state_q == S_READ) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == LAT) rdata_q <= load_data;
        end
    end

    always_comb begin
        lsu.req_ready  = (state_q == S_IDLE) && !rst;
        lsu.resp_valid = (state_q == S_RESP);
        lsu.resp_rdata = 32'h0;
        lsu.resp_err   = 1'b0;
        address_dm     = '0;
        writedata_dm   = 32'h0;
        byte_en        = 4'h0;
        memread_dm     = 1'b0;
        memwrite_dm    = 1'b0;
        case (state_q)
            S_WRITE: begin
                address_dm   = {addr_q[ADDR_W-1:2], 2'b00};
                writedata_dm = store_data(f3_q, wdata_q);
                byte_en      = store_be(f3_q, addr_q[1:0]);
                memwrite_dm  = 1'b1;
            end
            S_READ: begin
                address_dm = {addr_q[ADDR_W-1:2], 2'b00};
                memread_dm = 1'b1;
            end
            S_RESP: begin
                lsu.resp_rdata = rdata_q;
                lsu.resp_err   = err_q;
            end
            default: ;
        endcase
    end
endmodule
